// File: rtl/bm_memory_pkg.sv
// Shared definitions for the pipelined memory: FSM state encoding and
// default geometry. Read-during-write forwarding is selected in the top
// by the macro BM_MEMORY_WRITE_FORWARD_EN.
package bm_memory_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_t;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/bm_memory_array.sv
// Storage for the pipelined memory: one write port, one registered read
// port, no reset. The caller guarantees addresses are in range; the index
// width is the minimum that covers DEPTH words.
module bm_memory_array #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port: word updates at the clock edge
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // read port: samples the word before a same-edge write lands (read-first)
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bm_pipelined_memory.sv
// Pipelined memory with a power-up zero sweep and a 2-cycle read pipeline.
// Macro BM_MEMORY_WRITE_FORWARD_EN: when defined, a read and write to the
// same address in the same cycle returns the new data (write-first);
// otherwise the previously stored word is returned (read-first).
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | zero sweep, one word per cycle at init_ptr; requests ignored
// RUN   | ready; reads and writes accepted
module bm_pipelined_memory
  import bm_memory_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int IDX_W = $clog2(DEPTH);
  // one extra bit so DEPTH == 2**ADDR_W is still representable
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q;
  logic              init_last;

  logic              wr_ok, rd_ok, wr_acc, rd_acc;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_wa, arr_ra;
  logic [WIDTH-1:0]  arr_wd, arr_rd_data;

  logic              s1_valid, s1_oor;
  logic [WIDTH-1:0]  rd_word;

  assign init_last = (init_ptr_q == LAST_WORD);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // sweep pointer walks 0..DEPTH-1 while initialising
  always_ff @(posedge clock) begin
    if (reset)                 init_ptr_q <= '0;
    else if (state_q == INIT)  init_ptr_q <= init_last ? '0 : init_ptr_q + 1'b1;
  end

  // next-state: leave INIT once the last word has been zeroed
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = 1'b0;
    if (state_q == RUN) ready = 1'b1;
  end

  assign wr_ok  = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok  = ({1'b0, rd_addr} < DEPTH_C);
  assign wr_acc = ready && wr_en;
  assign rd_acc = ready && rd_req;

  // init mux: the sweep owns the write port until RUN; reset blocks all writes
  always_comb begin
    arr_we = 1'b0;
    arr_wa = wr_addr[IDX_W-1:0];
    arr_wd = wr_data;
    if (state_q == INIT) begin
      arr_we = !reset;
      arr_wa = init_ptr_q[IDX_W-1:0];
      arr_wd = '0;
    end else begin
      arr_we = !reset && wr_acc && wr_ok;
    end
  end

  // out-of-range reads are steered to word 0 and masked in stage 1
  assign arr_ra = rd_ok ? rd_addr[IDX_W-1:0] : '0;

  bm_memory_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock   (clock),
    .wr_en   (arr_we),
    .wr_addr (arr_wa),
    .wr_data (arr_wd),
    .rd_en   (rd_acc),
    .rd_addr (arr_ra),
    .rd_data (arr_rd_data)
  );

  // stage 1 valid: flushed by reset so in-flight reads vanish
  always_ff @(posedge clock) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= rd_acc;
  end

  // stage 1 side info travelling with the array read
  always_ff @(posedge clock) begin
    if (rd_acc) s1_oor <= !rd_ok;
  end

`ifdef BM_MEMORY_WRITE_FORWARD_EN
  logic             s1_fwd;
  logic [WIDTH-1:0] s1_fwd_data;

  // capture a same-address write so the read can return the new word
  always_ff @(posedge clock) begin
    if (rd_acc) begin
      s1_fwd      <= wr_acc && wr_ok && rd_ok && (wr_addr == rd_addr);
      s1_fwd_data <= wr_data;
    end
  end

  assign rd_word = s1_oor ? '0 : (s1_fwd ? s1_fwd_data : arr_rd_data);
`else
  assign rd_word = s1_oor ? '0 : arr_rd_data;
`endif

  // stage 2: strobe the result, hold rd_data between strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= s1_valid;
      if (s1_valid) rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_bm_pipelined_memory.sv
// Bench for bm_pipelined_memory: two instances (DEPTH 8 and DEPTH 6) share
// the same stimulus; a word-level model predicts ready and each read result,
// a monitor compares the DUT against the expected-response queues.
module tb_bm_pipelined_memory;

  typedef struct {
    int         due;
    logic [2:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en, rd_req;
  logic [3:0] wr_addr, rd_addr;
  logic [2:0] wr_data;

  logic       rdy [2];
  logic       rdv [2];
  logic [2:0] rdd [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  bm_pipelined_memory #(.WIDTH(3), .DEPTH(8), .ADDR_W(4)) dut_a (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .ready(rdy[0]), .rd_valid(rdv[0]), .rd_data(rdd[0]));

  bm_pipelined_memory #(.WIDTH(3), .DEPTH(6), .ADDR_W(4)) dut_b (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .ready(rdy[1]), .rd_valid(rdv[1]), .rd_data(rdd[1]));

  function automatic int dep(int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  exp_t       q0[$], q1[$];
  logic [2:0] mmem [2][16];
  int         init_left [2];
  int         cyc     = 0;
  int         rst_cnt = 0;
  bit         started = 0;

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic void qpush(int k, exp_t e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endfunction
  function automatic exp_t qpop(int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction
  function automatic int qdue(int k);
    return (k == 0) ? q0[0].due : q1[0].due;
  endfunction
  function automatic void qclear(int k);
    if (k == 0) q0.delete(); else q1.delete();
  endfunction

  always @(posedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      rst_cnt++;
      started = 1;
    end
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        // after the sweep every word is zero; nothing can read before then
        init_left[k] = dep(k);
        for (int a = 0; a < 16; a++) mmem[k][a] = 3'd0;
        qclear(k);
      end else if (init_left[k] > 0) begin
        init_left[k]--;
      end else begin
        if (rd_req) begin
          e.due  = cyc + 1;
          e.data = (int'(rd_addr) < dep(k)) ? mmem[k][rd_addr] : 3'd0;
`ifdef BM_MEMORY_WRITE_FORWARD_EN
          if (wr_en && wr_addr == rd_addr && int'(rd_addr) < dep(k)) e.data = wr_data;
`endif
          qpush(k, e);
        end
        if (wr_en && int'(wr_addr) < dep(k)) mmem[k][wr_addr] = wr_data;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [2:0] hold [2];
  int         seen_rst [2] = '{0, 0};

  always @(negedge clock) begin
    exp_t e;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        if (seen_rst[k] != rst_cnt) begin
          seen_rst[k] = rst_cnt;
          hold[k]     = 3'd0;
        end
        chk("ready", k, 32'(rdy[k]), 32'(init_left[k] == 0));
        if (qsize(k) > 0 && qdue(k) <= cyc) begin
          e = qpop(k);
          chk("rd_valid", k, 32'(rdv[k]), 32'd1);
          chk("rd_data", k, 32'(rdd[k]), 32'(e.data));
          hold[k] = e.data;
        end else begin
          chk("rd_valid_idle", k, 32'(rdv[k]), 32'd0);
          chk("rd_data_hold", k, 32'(rdd[k]), 32'(hold[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit rst, bit we, int wa, int wd, bit re, int ra);
    @(negedge clock);
    reset   = rst;
    wr_en   = we;
    wr_addr = 4'(wa);
    wr_data = 3'(wd);
    rd_req  = re;
    rd_addr = 4'(ra);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // issue a read, then check both instances two cycles later
  task automatic read_check(string nm, int a, int e0, int e1);
    drive(0, 0, 0, 0, 1, a);
    idle(1);
    @(negedge clock);
    chk({nm, "_valid"}, 0, 32'(rdv[0]), 32'd1);
    chk({nm, "_data"},  0, 32'(rdd[0]), 32'(e0));
    chk({nm, "_valid"}, 1, 32'(rdv[1]), 32'd1);
    chk({nm, "_data"},  1, 32'(rdd[1]), 32'(e1));
  endtask

  // release reset (already driven for one cycle) and count ready-low cycles
  task automatic count_init(string nm);
    int c0 = 0, c1 = 0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !(rdy[0] && rdy[1]); i++) begin
      if (!rdy[0]) c0++;
      if (!rdy[1]) c1++;
      @(negedge clock);
    end
    chk(nm, 0, 32'(c0), 32'd8);
    chk(nm, 1, 32'(c1), 32'd6);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) @(negedge clock);
    count_init("init_len");

    // every address, in range and not, reads zero after the sweep
    for (int a = 0; a < 16; a++) drive(0, 0, 0, 0, 1, a);
    idle(3);

    drive(0, 1, 3, 5, 0, 0);
    read_check("wr5_rd3", 3, 5, 5);

    drive(0, 1, 0, 1, 0, 0);
    drive(0, 1, 1, 2, 0, 0);
    drive(0, 1, 2, 3, 0, 0);
    for (int a = 0; a < 3; a++) drive(0, 0, 0, 0, 1, a);
    idle(3);

    drive(0, 1, 4, 2, 0, 0);
`ifdef BM_MEMORY_WRITE_FORWARD_EN
    drive(0, 1, 4, 6, 1, 4);
    idle(1);
    @(negedge clock);
    chk("rdw_same", 0, 32'(rdd[0]), 32'd6);
`else
    drive(0, 1, 4, 6, 1, 4);
    idle(1);
    @(negedge clock);
    chk("rdw_same", 0, 32'(rdd[0]), 32'd2);
`endif
    read_check("rd4_after", 4, 6, 6);

    // address 6 exists only in the DEPTH=8 instance
    drive(0, 1, 6, 7, 0, 0);
    read_check("oor6", 6, 7, 0);
    for (int a = 0; a < 6; a++) drive(0, 0, 0, 0, 1, a);
    idle(3);

    // reset one cycle after a read request: no strobe, full re-sweep, data lost
    drive(0, 1, 5, 4, 0, 0);
    drive(0, 0, 0, 0, 1, 5);
    drive(1, 0, 0, 0, 0, 0);
    count_init("init_len_rst");
    read_check("after_rst", 5, 0, 0);

    // reset in the middle of the sweep, with requests that must be ignored
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 7, 1, 1);
    drive(0, 1, 2, 7, 1, 2);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    count_init("init_len_mid");
    read_check("mid_rst_rd", 1, 0, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 149) == 0, 1'($urandom), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 15)));
    end
    idle(20);

    chk("drain", 0, 32'(qsize(0)), 32'd0);
    chk("drain", 1, 32'(qsize(1)), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
